// File: rtl/mfcc_frame_sequencer.sv
// Frame-level controller for the MFCC front end: sequences window -> hamming -> FFT per frame,
// holds each power frame until acked, then slides the window and repeats.
module mfcc_frame_sequencer #(
   parameter int unsigned NUM_FRAMES     = 0,
   parameter int unsigned RFFT_BINS      = 257,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned FRAME_IDX_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic                   window_ready_i,
   output logic                   start_move_o,
   output logic                   hamming_start_o,
   input  logic                   hamming_done_i,
   output logic                   fft_start_o,
   input  logic                   power_valid_i,
   input  logic                   fft_done_i,
   output logic                   frame_valid_o,
   input  logic                   frame_ack_i,
   output logic [FRAME_IDX_W-1:0] frame_idx_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   error_o
);

   localparam int unsigned BinW = $clog2(RFFT_BINS + 2);
   localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [BinW-1:0] BinMax = BinW'(RFFT_BINS + 1);
   localparam logic [BinW-1:0] BinExp = BinW'(RFFT_BINS);
   localparam logic [WdW-1:0]  WdLast = WdW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle, StWaitWin, StHamm, StFft, StHold, StAdvance
   } state_e;

   state_e          state_q;
   logic [BinW-1:0] bin_cnt_q;
   logic [WdW-1:0]  wd_cnt_q;

   logic            bin_inc;
   logic [BinW-1:0] bin_now;
   logic            wd_trip;
   logic            last_frame;

   always_comb begin
      bin_inc    = power_valid_i && (bin_cnt_q != BinMax);
      // Count as it stands including a beat arriving alongside fft_done_i.
      bin_now    = bin_cnt_q + BinW'(bin_inc);
      wd_trip    = (state_q inside {StWaitWin, StHamm, StFft}) && (wd_cnt_q == WdLast);
      last_frame = (NUM_FRAMES != 0) && ((32'(frame_idx_o) + 32'd1) == NUM_FRAMES);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         bin_cnt_q       <= '0;
         wd_cnt_q        <= '0;
         start_move_o    <= 1'b0;
         hamming_start_o <= 1'b0;
         fft_start_o     <= 1'b0;
         frame_valid_o   <= 1'b0;
         frame_idx_o     <= '0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         error_o         <= 1'b0;
      end else begin
         start_move_o    <= 1'b0;
         hamming_start_o <= 1'b0;
         fft_start_o     <= 1'b0;
         done_o          <= 1'b0;
         wd_cnt_q        <= wd_cnt_q + WdW'(1);

         if (abort_i && (state_q != StIdle)) begin
            state_q       <= StIdle;
            busy_o        <= 1'b0;
            frame_valid_o <= 1'b0;
         end else if (wd_trip) begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
            error_o <= 1'b1;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start_i) begin
                     state_q     <= StWaitWin;
                     busy_o      <= 1'b1;
                     error_o     <= 1'b0;
                     frame_idx_o <= '0;
                     wd_cnt_q    <= '0;
                  end
               end
               StWaitWin: begin
                  if (window_ready_i) begin
                     state_q         <= StHamm;
                     hamming_start_o <= 1'b1;
                     wd_cnt_q        <= '0;
                  end
               end
               StHamm: begin
                  if (hamming_done_i) begin
                     state_q     <= StFft;
                     fft_start_o <= 1'b1;
                     bin_cnt_q   <= '0;
                     wd_cnt_q    <= '0;
                  end
               end
               StFft: begin
                  bin_cnt_q <= bin_now;
                  if (fft_done_i) begin
                     if (bin_now != BinExp) error_o <= 1'b1;
                     state_q       <= StHold;
                     frame_valid_o <= 1'b1;
                     wd_cnt_q      <= '0;
                  end
               end
               StHold: begin
                  if (frame_ack_i) begin
                     frame_valid_o <= 1'b0;
                     frame_idx_o   <= frame_idx_o + FRAME_IDX_W'(1);
                     if (last_frame) begin
                        state_q <= StIdle;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                     end else begin
                        state_q      <= StAdvance;
                        start_move_o <= 1'b1;
                     end
                  end
               end
               StAdvance: begin
                  state_q  <= StWaitWin;
                  wd_cnt_q <= '0;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
